// File: rtl/mt9v_capture_ctrl.sv
// MT9V frame capture sequencer: arms on request, aligns to a clean frame start,
// emits a qualified pixel stream with coordinates and frame/line markers, and
// checks each captured frame's geometry against the configured resolution.
module mt9v_capture_ctrl #(
  parameter int unsigned H_ACTIVE = 752,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9
) (
  input  logic           pclk,
  input  logic           rst_n,
  input  logic [7:0]     data_in,
  input  logic           fm_in,
  input  logic           ln_in,
  input  logic           cap_req,
  input  logic           cap_cont,
  input  logic           abort,
  output logic [7:0]     pix_data,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           sof,
  output logic           eol,
  output logic           eof,
  output logic           busy,
  output logic           err_hlen,
  output logic           err_vlen
);

  localparam logic [X_W-1:0] XMax = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] YMax = Y_W'(V_ACTIVE);

  typedef enum logic [1:0] {StIdle, StWaitGap, StWaitSof, StActive} state_e;

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           ln_prev_q, fm_prev_q;
  logic           err_hlen_q, err_hlen_d;
  logic           err_vlen_q, err_vlen_d;
  logic [7:0]     pix_data_q, pix_data_d;
  logic [X_W-1:0] pix_x_q, pix_x_d;
  logic [Y_W-1:0] pix_y_q, pix_y_d;
  logic           pix_valid_q, pix_valid_d;
  logic           sof_q, sof_d;
  logic           eol_q, eol_d;
  logic           eof_q, eof_d;
  logic           busy_q;

  logic           ln_fall, fm_fall, pix_acc;
  logic [Y_W-1:0] y_line;

  assign ln_fall = ln_prev_q & ~ln_in;
  assign fm_fall = fm_prev_q & ~fm_in;
  assign pix_acc = fm_in & ln_in;

  // Next-state, counters, error flags and registered output values.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    err_hlen_d  = err_hlen_q;
    err_vlen_d  = err_vlen_q;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_valid_d = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    eof_d       = 1'b0;
    y_line      = y_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (cap_req) begin
            state_d    = StWaitGap;
            err_hlen_d = 1'b0;
            err_vlen_d = 1'b0;
          end
        end
        // Never start mid-frame: wait for frame valid to drop first.
        StWaitGap: begin
          if (!fm_in) state_d = StWaitSof;
        end
        StWaitSof: begin
          x_d = '0;
          y_d = '0;
          if (fm_in) state_d = StActive;
        end
        StActive: begin
          if (pix_acc) begin
            if (x_q < XMax && y_q < YMax) begin
              pix_valid_d = 1'b1;
              pix_data_d  = data_in;
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              sof_d       = (x_q == '0) && (y_q == '0);
            end
            if (x_q >= XMax) err_hlen_d = 1'b1;
            if (y_q >= YMax) err_vlen_d = 1'b1;
            if (x_q < XMax) x_d = x_q + 1'b1;
          end
          // Line is counted before the frame-end line check when both fall together.
          if (ln_fall) begin
            eol_d = 1'b1;
            if (x_q != XMax) err_hlen_d = 1'b1;
            x_d = '0;
            if (y_q < YMax) y_line = y_q + 1'b1;
            y_d = y_line;
          end
          if (fm_fall) begin
            eof_d = 1'b1;
            if (y_line != YMax) err_vlen_d = 1'b1;
            state_d = cap_cont ? StWaitSof : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      ln_prev_q   <= 1'b0;
      fm_prev_q   <= 1'b0;
      err_hlen_q  <= 1'b0;
      err_vlen_q  <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ln_prev_q   <= ln_in;
      fm_prev_q   <= fm_in;
      err_hlen_q  <= err_hlen_d;
      err_vlen_q  <= err_vlen_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_valid_q <= pix_valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      busy_q      <= (state_q != StIdle);
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign err_hlen  = err_hlen_q;
  assign err_vlen  = err_vlen_q;

endmodule

// File: tb/tb_mt9v_capture_ctrl.sv
// Directed bench for mt9v_capture_ctrl with a pixel scoreboard (H=4, V=3).
module tb_mt9v_capture_ctrl;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int XW = 3;
  localparam int YW = 2;

  logic          pclk = 1'b0;
  logic          rst_n;
  logic [7:0]    data_in;
  logic          fm_in, ln_in, cap_req, cap_cont, abort;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          sof, eol, eof, busy, err_hlen, err_vlen;

  always #5 pclk = ~pclk;

  mt9v_capture_ctrl #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .X_W     (XW),
    .Y_W     (YW)
  ) dut (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .fm_in    (fm_in),
    .ln_in    (ln_in),
    .cap_req  (cap_req),
    .cap_cont (cap_cont),
    .abort    (abort),
    .pix_data (pix_data),
    .pix_valid(pix_valid),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .sof      (sof),
    .eol      (eol),
    .eof      (eof),
    .busy     (busy),
    .err_hlen (err_hlen),
    .err_vlen (err_vlen)
  );

  typedef struct packed {
    logic [7:0]    d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          s;
  } pix_t;

  pix_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_sof = 0, n_eol = 0, n_eof = 0, n_both = 0;
  int b_sof, b_eol, b_eof, b_both;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  // Output monitor: pops the scoreboard on each valid pixel and counts markers.
  always @(negedge pclk) begin : mon
    pix_t e;
    if (pix_valid) begin
      chk("pix_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pix", 32'({pix_data, pix_x, pix_y, sof}), 32'(e));
      end
    end
    if (sof) n_sof++;
    if (eol) n_eol++;
    if (eof) n_eof++;
    if (eol && eof) n_both++;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_req();
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
  endtask

  task automatic mark();
    b_sof  = n_sof;
    b_eol  = n_eol;
    b_eof  = n_eof;
    b_both = n_both;
  endtask

  task automatic counts(input string t, input int es, input int el, input int ef);
    chk({t, "_sof"}, n_sof - b_sof, es);
    chk({t, "_eol"}, n_eol - b_eol, el);
    chk({t, "_eof"}, n_eof - b_eof, ef);
  endtask

  task automatic idle_ok(input string t, input logic eh, input logic ev);
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_errs"}, 32'({err_hlen, err_vlen}), 32'({eh, ev}));
    chk({t, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Drives one frame; ev_kind at (ev_line, pixel 1): 1 abort, 2 reset, 3 cap_req.
  task automatic drive_frame(input int nlines, input int first_len, input bit push,
                             input bit simul, input int ev_line, input int ev_kind);
    int idx;
    bit pon;
    pix_t e;
    idx = 0;
    pon = push;
    fm_in = 1'b0;
    ln_in = 1'b0;
    repeat (2) tick();
    fm_in = 1'b1;
    tick();
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == 0) ? first_len : H;
      for (int p = 0; p < len; p++) begin
        bit evh;
        evh = (l == ev_line) && (p == 1);
        data_in = 8'h10 + idx[7:0];
        ln_in = 1'b1;
        if (evh) begin
          case (ev_kind)
            1: abort = 1'b1;
            2: rst_n = 1'b0;
            3: cap_req = 1'b1;
            default: ;
          endcase
          if (ev_kind == 1 || ev_kind == 2) pon = 1'b0;
        end
        if (pon && p < H && l < V) begin
          e.d = data_in;
          e.x = p[XW-1:0];
          e.y = l[YW-1:0];
          e.s = (p == 0) && (l == 0);
          exp_q.push_back(e);
        end
        tick();
        abort = 1'b0;
        cap_req = 1'b0;
        if (evh && ev_kind == 2) begin
          chk("reset_mid_outputs", 32'({pix_data, pix_x, pix_y, pix_valid, sof, eol, eof,
                                        busy, err_hlen, err_vlen}), 32'd0);
          rst_n = 1'b1;
        end
        idx++;
      end
      ln_in = 1'b0;
      if (simul && l == nlines - 1) fm_in = 1'b0;
      tick();
      if (l != nlines - 1) tick();
    end
    if (!simul) begin
      tick();
      fm_in = 1'b0;
      tick();
    end
    fm_in = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    data_in  = '0;
    fm_in    = 1'b0;
    ln_in    = 1'b0;
    cap_req  = 1'b0;
    cap_cont = 1'b0;
    abort    = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 32'({pix_data, pix_x, pix_y, pix_valid, sof, eol, eof, busy,
                              err_hlen, err_vlen}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single frame
    mark();
    pulse_req();
    tick();
    chk("t1_busy_high", 32'(busy), 32'd1);
    drive_frame(3, 4, 1'b1, 1'b0, -1, 0);
    counts("t1", 1, 3, 1);
    idle_ok("t1", 1'b0, 1'b0);

    // 2: arm mid-frame, capture only the next full frame
    mark();
    drive_frame(3, 4, 1'b0, 1'b0, 1, 3);
    counts("t2_skip", 0, 0, 0);
    drive_frame(3, 4, 1'b1, 1'b0, -1, 0);
    counts("t2", 1, 3, 1);
    idle_ok("t2", 1'b0, 1'b0);

    // 3: 5-pixel line and only 2 lines
    mark();
    pulse_req();
    drive_frame(2, 5, 1'b1, 1'b0, -1, 0);
    counts("t3", 1, 2, 1);
    idle_ok("t3", 1'b1, 1'b1);
    pulse_req();
    chk("t3_err_clear", 32'({err_hlen, err_vlen}), 32'd0);
    drive_frame(3, 4, 1'b1, 1'b0, -1, 0);
    idle_ok("t3_clean", 1'b0, 1'b0);

    // 4: continuous mode for two frames
    mark();
    cap_cont = 1'b1;
    pulse_req();
    drive_frame(3, 4, 1'b1, 1'b0, -1, 0);
    chk("t4_busy_between", 32'(busy), 32'd1);
    cap_cont = 1'b0;
    drive_frame(3, 4, 1'b1, 1'b0, -1, 0);
    counts("t4", 2, 6, 2);
    idle_ok("t4", 1'b0, 1'b0);

    // 5a: abort during line 2
    mark();
    pulse_req();
    drive_frame(3, 4, 1'b1, 1'b0, 2, 1);
    counts("t5_abort", 1, 2, 0);
    idle_ok("t5_abort", 1'b0, 1'b0);

    // 5b: reset during line 1, then a normal capture
    mark();
    pulse_req();
    drive_frame(3, 4, 1'b1, 1'b0, 1, 2);
    counts("t5_reset", 1, 1, 0);
    idle_ok("t5_reset", 1'b0, 1'b0);
    mark();
    pulse_req();
    drive_frame(3, 4, 1'b1, 1'b0, -1, 0);
    counts("t5_after", 1, 3, 1);
    idle_ok("t5_after", 1'b0, 1'b0);

    // 6: fm and ln fall together on the last line
    mark();
    pulse_req();
    drive_frame(3, 4, 1'b1, 1'b1, -1, 0);
    counts("t6", 1, 3, 1);
    chk("t6_eol_eof_same", n_both - b_both, 1);
    idle_ok("t6", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
